// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, init FSM states and helpers (SDRAM_INIT_EMRS_EN adds EMRS states)
package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PREA = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MSET = 4'b0000;

  // A10 selects "all banks" for PREA
  localparam int A10_BIT = 10;

  typedef enum logic [3:0] {
    ST_PWR_WAIT,
    ST_PRE,
    ST_TRP_WAIT,
    ST_REF,
    ST_TRFC_WAIT,
    ST_MRS,
    ST_TMRD_WAIT,
`ifdef SDRAM_INIT_EMRS_EN
    ST_EMRS,
    ST_EMRD_WAIT,
`endif
    ST_DONE
  } init_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sdram_dly_cnt.sv
// rtl/sdram_dly_cnt.sv - loadable down-counter that holds at zero and flags it
module sdram_dly_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load wins; otherwise count down and park at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// rtl/sdram_init_seq.sv - parametrised SDRAM power-up init sequencer (SDRAM_INIT_EMRS_EN adds the extended mode-set)
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int                ADDR_W      = 13,
  parameter int                POWERUP_CYC = 10000,
  parameter int                TRP_CYC     = 1,
  parameter int                REF_NUM     = 8,
  parameter int                TRFC_CYC    = 3,
  parameter int                TMRD_CYC    = 2,
  parameter logic [ADDR_W-1:0] MODE_REG    = 'h032
`ifdef SDRAM_INIT_EMRS_EN
  ,
  parameter logic [ADDR_W-1:0] EMODE_REG   = 'h000
`endif
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              init_req,
  output logic [3:0]        cmd_reg,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [1:0]        sdram_ba,
  output logic              init_busy,
  output logic              flag_init_end
);

  localparam int CNT_W = $clog2(max4(POWERUP_CYC, TRP_CYC, TRFC_CYC, TMRD_CYC)) + 1;
  localparam int REF_W = $clog2(REF_NUM + 1);

  // Wait states last N cycles: load N-1 on entry, leave when the counter reads zero.
  localparam logic [CNT_W-1:0] LD_PWR  = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_TRP  = CNT_W'(TRP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_TRFC = CNT_W'(TRFC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_TMRD = CNT_W'(TMRD_CYC - 1);

  localparam logic [ADDR_W-1:0] ADDR_A10 = ADDR_W'(1) << A10_BIT;

  init_state_t       r_state;
  init_state_t       w_next;
  init_state_t       w_after_ref;
  init_state_t       w_after_mrd;
  logic              w_cnt_zero;
  logic              w_cnt_load;
  logic [CNT_W-1:0]  w_cnt_val;
  logic [REF_W-1:0]  r_ref_cnt;

  logic [3:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_ba;
  logic              w_busy;
  logic              w_flag;
  logic [3:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_ba;
  logic              r_busy;
  logic              r_flag;

  sdram_dly_cnt #(.W(CNT_W)) u_dly_cnt (
    .clk        (sclk),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_zero     (w_cnt_zero)
  );

  // Next state; the refresh counter already counts the AREF in progress, so zero means none left.
  always_comb begin
    w_next      = r_state;
    w_after_ref = (r_ref_cnt != '0) ? ST_REF : ST_MRS;
`ifdef SDRAM_INIT_EMRS_EN
    w_after_mrd = ST_EMRS;
`else
    w_after_mrd = ST_DONE;
`endif
    case (r_state)
      ST_PWR_WAIT:  if (w_cnt_zero) w_next = ST_PRE;
      ST_PRE:       w_next = (TRP_CYC > 0) ? ST_TRP_WAIT : ST_REF;
      ST_TRP_WAIT:  if (w_cnt_zero) w_next = ST_REF;
      ST_REF:       w_next = (TRFC_CYC > 0) ? ST_TRFC_WAIT : w_after_ref;
      ST_TRFC_WAIT: if (w_cnt_zero) w_next = w_after_ref;
      ST_MRS:       w_next = (TMRD_CYC > 0) ? ST_TMRD_WAIT : w_after_mrd;
      ST_TMRD_WAIT: if (w_cnt_zero) w_next = w_after_mrd;
`ifdef SDRAM_INIT_EMRS_EN
      ST_EMRS:      w_next = (TMRD_CYC > 0) ? ST_EMRD_WAIT : ST_DONE;
      ST_EMRD_WAIT: if (w_cnt_zero) w_next = ST_DONE;
`endif
      ST_DONE:      if (init_req) w_next = ST_PRE;
      default:      w_next = ST_PWR_WAIT;
    endcase
  end

  // Shared delay counter is (re)loaded whenever a wait state is entered, and by reset for power-up.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    if (s_rst) begin
      w_cnt_load = 1'b1;
      w_cnt_val  = LD_PWR;
    end else if (w_next != r_state) begin
      case (w_next)
        ST_TRP_WAIT:  begin w_cnt_load = 1'b1; w_cnt_val = LD_TRP;  end
        ST_TRFC_WAIT: begin w_cnt_load = 1'b1; w_cnt_val = LD_TRFC; end
        ST_TMRD_WAIT: begin w_cnt_load = 1'b1; w_cnt_val = LD_TMRD; end
`ifdef SDRAM_INIT_EMRS_EN
        ST_EMRD_WAIT: begin w_cnt_load = 1'b1; w_cnt_val = LD_TMRD; end
`endif
        default: ;
      endcase
    end
  end

  // Bus values for the state being entered, so the registered outputs line up with the state.
  always_comb begin
    w_cmd  = CMD_NOP;
    w_addr = ADDR_A10;
    w_ba   = 2'b00;
    w_busy = 1'b1;
    w_flag = 1'b0;
    case (w_next)
      ST_PRE: w_cmd = CMD_PREA;
      ST_REF: w_cmd = CMD_AREF;
      ST_MRS: begin
        w_cmd  = CMD_MSET;
        w_addr = MODE_REG;
      end
`ifdef SDRAM_INIT_EMRS_EN
      ST_EMRS: begin
        w_cmd  = CMD_MSET;
        w_addr = EMODE_REG;
        w_ba   = 2'b10;
      end
`endif
      ST_DONE: begin
        w_busy = 1'b0;
        w_flag = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers; reset restarts the full power-up wait.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_state <= ST_PWR_WAIT;
      r_cmd   <= CMD_NOP;
      r_addr  <= ADDR_A10;
      r_ba    <= 2'b00;
      r_busy  <= 1'b1;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cmd   <= w_cmd;
      r_addr  <= w_addr;
      r_ba    <= w_ba;
      r_busy  <= w_busy;
      r_flag  <= w_flag;
    end
  end

  // Refresh counter: reloaded at each PREA, decremented as each AREF is issued.
  always_ff @(posedge sclk) begin
    if (s_rst || (w_next == ST_PRE)) begin
      r_ref_cnt <= REF_W'(REF_NUM);
    end else if (w_next == ST_REF) begin
      r_ref_cnt <= r_ref_cnt - REF_W'(1);
    end
  end

  assign cmd_reg       = r_cmd;
  assign sdram_addr    = r_addr;
  assign sdram_ba      = r_ba;
  assign init_busy     = r_busy;
  assign flag_init_end = r_flag;

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb/tb_sdram_init_seq.sv - bench for sdram_init_seq: default and short-timing instances against a schedule model
module tb_sdram_init_seq;

  localparam logic [3:0]  C_NOP  = 4'b0111;
  localparam logic [3:0]  C_PREA = 4'b0010;
  localparam logic [3:0]  C_AREF = 4'b0001;
  localparam logic [3:0]  C_MSET = 4'b0000;
  localparam logic [12:0] A10    = 13'h0400;
`ifdef SDRAM_INIT_EMRS_EN
  localparam bit EMRS   = 1'b1;
  localparam int A_FL   = 10040;
  localparam int B_DONE = 4;
`else
  localparam bit EMRS   = 1'b0;
  localparam int A_FL   = 10037;
  localparam int B_DONE = 3;
`endif

  typedef struct {
    int          p;
    int          trp;
    int          nref;
    int          trfc;
    int          tmrd;
    logic [12:0] mode;
    logic [12:0] emode;
    bit          emrs;
  } cfg_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, req_a, req_b;
  logic [3:0]  cmd_a, cmd_b;
  logic [12:0] addr_a, addr_b;
  logic [1:0]  ba_a, ba_b;
  logic        busy_a, busy_b, flag_a, flag_b;

  int   total = 0;
  int   bad   = 0;
  cfg_t cfg_a, cfg_b;
  int   rel_a = 0, rel_b = 0;
  bit   live_a = 1'b0, live_b = 1'b0;

  always #5 clk = ~clk;

  sdram_init_seq #(
`ifdef SDRAM_INIT_EMRS_EN
    .EMODE_REG   (13'h040),
`endif
    .ADDR_W      (13)
  ) u_dut_a (
    .sclk          (clk),
    .s_rst         (rst_a),
    .init_req      (req_a),
    .cmd_reg       (cmd_a),
    .sdram_addr    (addr_a),
    .sdram_ba      (ba_a),
    .init_busy     (busy_a),
    .flag_init_end (flag_a)
  );

  sdram_init_seq #(
    .ADDR_W      (13),
    .POWERUP_CYC (5),
    .TRP_CYC     (0),
    .REF_NUM     (1),
    .TRFC_CYC    (0),
    .TMRD_CYC    (0)
  ) u_dut_b (
    .sclk          (clk),
    .s_rst         (rst_b),
    .init_req      (req_b),
    .cmd_reg       (cmd_b),
    .sdram_addr    (addr_b),
    .sdram_ba      (ba_b),
    .init_busy     (busy_b),
    .flag_init_end (flag_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h want 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offset from PREA at which the bus is handed back.
  function automatic int done_rel(input cfg_t c);
    int mset;
    mset = 1 + c.trp + c.nref * (c.trfc + 1);
    return mset + (c.tmrd + 1) * (c.emrs ? 2 : 1);
  endfunction

  // Expected {cmd, addr, ba, busy, flag} at offset rel from PREA (negative: still powering up).
  function automatic logic [20:0] model_exp(input cfg_t c, input int rel);
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        busy, flag;
    int per, first, last, mset, emrs_at;
    cmd = C_NOP; addr = A10; ba = 2'b00; busy = 1'b1; flag = 1'b0;
    per     = c.trfc + 1;
    first   = 1 + c.trp;
    last    = first + (c.nref - 1) * per;
    mset    = last + per;
    emrs_at = mset + c.tmrd + 1;
    if (rel == 0) cmd = C_PREA;
    else if (rel >= first && rel <= last && ((rel - first) % per) == 0) cmd = C_AREF;
    else if (rel == mset) begin cmd = C_MSET; addr = c.mode; end
    else if (c.emrs && rel == emrs_at) begin cmd = C_MSET; addr = c.emode; ba = 2'b10; end
    if (rel >= done_rel(c)) begin busy = 1'b0; flag = 1'b1; end
    return {cmd, addr, ba, busy, flag};
  endfunction

  function automatic logic [3:0] model_cmd(input cfg_t c, input int rel);
    logic [20:0] v;
    v = model_exp(c, rel);
    return v[20:17];
  endfunction

  // Model time base: reset reloads the power-up offset, a request in DONE restarts at PREA.
  always @(posedge clk) begin
    if (rst_a) begin rel_a <= -cfg_a.p; live_a <= 1'b1; end
    else if (rel_a >= done_rel(cfg_a) && req_a) rel_a <= 0;
    else rel_a <= rel_a + 1;
    if (rst_b) begin rel_b <= -cfg_b.p; live_b <= 1'b1; end
    else if (rel_b >= done_rel(cfg_b) && req_b) rel_b <= 0;
    else rel_b <= rel_b + 1;
  end

  // Per-cycle comparison of both instances against the model, away from the active edge.
  always @(negedge clk) begin
    if (live_a) chk("model_a", {cmd_a, addr_a, ba_a, busy_a, flag_a}, model_exp(cfg_a, rel_a));
    if (live_b) chk("model_b", {cmd_b, addr_b, ba_b, busy_b, flag_b}, model_exp(cfg_b, rel_b));
  end

  initial begin
    cfg_a = '{p: 10000, trp: 1, nref: 8, trfc: 3, tmrd: 2, mode: 13'h032, emode: 13'h040, emrs: EMRS};
    cfg_b = '{p: 5, trp: 0, nref: 1, trfc: 0, tmrd: 0, mode: 13'h032, emode: 13'h000, emrs: EMRS};
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;

    chk("pin_a_aref2",  model_cmd(cfg_a, 2), C_AREF);
    chk("pin_a_aref30", model_cmd(cfg_a, 30), C_AREF);
    chk("pin_a_nop31",  model_cmd(cfg_a, 31), C_NOP);
    chk("pin_a_mset34", model_cmd(cfg_a, 34), C_MSET);
    chk("pin_a_done",   done_rel(cfg_a), A_FL - 10000);
    chk("pin_b_mset2",  model_cmd(cfg_b, 2), C_MSET);
    chk("pin_b_done",   done_rel(cfg_b), B_DONE);

    repeat (3) @(negedge clk);
    chk("rst_a_cmd",  cmd_a, C_NOP);
    chk("rst_a_addr", addr_a, A10);
    chk("rst_a_ba",   ba_a, 2'b00);
    chk("rst_a_busy", busy_a, 1'b1);
    chk("rst_a_flag", flag_a, 1'b0);
    chk("rst_b_cmd",  cmd_b, C_NOP);
    rst_a = 1'b0; rst_b = 1'b0;   // this cycle is cycle 0 for both

    fork
      begin : br_a
        repeat (10000) @(negedge clk);
        chk("a_prea_10000", cmd_a, C_PREA);
        repeat (2) @(negedge clk);
        chk("a_aref_10002", cmd_a, C_AREF);
        repeat (28) @(negedge clk);
        chk("a_aref_10030", cmd_a, C_AREF);
        repeat (4) @(negedge clk);
        chk("a_mset_10034", cmd_a, C_MSET);
        chk("a_mode_10034", addr_a, 13'h032);
        repeat (2) @(negedge clk);
        chk("a_flag_10036", flag_a, 1'b0);
        @(negedge clk);
`ifdef SDRAM_INIT_EMRS_EN
        chk("a_emrs_10037", cmd_a, C_MSET);
        chk("a_emba_10037", ba_a, 2'b10);
        chk("a_emad_10037", addr_a, 13'h040);
        repeat (3) @(negedge clk);
`endif
        chk("a_flag_end", flag_a, 1'b1);
        chk("a_busy_end", busy_a, 1'b0);
        repeat (3) @(negedge clk);
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        chk("a_re_prea", cmd_a, C_PREA);
        chk("a_re_flag", flag_a, 1'b0);
        repeat (4) @(negedge clk);
        req_a = 1'b1;                 // mid-sequence, must be ignored
        @(negedge clk);
        req_a = 1'b0;
        chk("a_ign_nop", cmd_a, C_NOP);
        @(negedge clk);
        chk("a_ign_aref", cmd_a, C_AREF);
        repeat (4) @(negedge clk);
        chk("a_aref_rel10", cmd_a, C_AREF);
        rst_a = 1'b1;
        @(negedge clk);
        chk("a_rst_cmd",  cmd_a, C_NOP);
        chk("a_rst_busy", busy_a, 1'b1);
        rst_a = 1'b0;
        repeat (9999) @(negedge clk);
        chk("a_rst_nop9999", cmd_a, C_NOP);
        @(negedge clk);
        chk("a_rst_prea", cmd_a, C_PREA);
        repeat (A_FL - 10000) @(negedge clk);
        chk("a_rst_flag", flag_a, 1'b1);
      end
      begin : br_b
        repeat (4) @(negedge clk);
        chk("b_nop_4", cmd_b, C_NOP);
        @(negedge clk);
        chk("b_prea_5", cmd_b, C_PREA);
        @(negedge clk);
        chk("b_aref_6", cmd_b, C_AREF);
        @(negedge clk);
        chk("b_mset_7", cmd_b, C_MSET);
        chk("b_mode_7", addr_b, 13'h032);
        repeat (B_DONE - 2) @(negedge clk);
        chk("b_flag_end", flag_b, 1'b1);
        repeat (2) @(negedge clk);
        req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        chk("b_re_prea", cmd_b, C_PREA);
        chk("b_re_flag", flag_b, 1'b0);
        @(negedge clk);
        chk("b_re_aref", cmd_b, C_AREF);
        req_b = 1'b1;                 // during AREF, must be ignored
        @(negedge clk);
        req_b = 1'b0;
        chk("b_ign_mset", cmd_b, C_MSET);
        repeat (B_DONE - 2) @(negedge clk);
        chk("b_re_done", flag_b, 1'b1);
        rst_b = 1'b1;                 // reset while in DONE
        @(negedge clk);
        chk("b_rst_done_flag", flag_b, 1'b0);
        rst_b = 1'b0;
        repeat (5) @(negedge clk);
        chk("b_prea_after_rst", cmd_b, C_PREA);
        @(negedge clk);
        chk("b_aref2", cmd_b, C_AREF);
        rst_b = 1'b1;                 // reset during the AREF phase
        @(negedge clk);
        chk("b_rst_cmd",  cmd_b, C_NOP);
        chk("b_rst_busy", busy_b, 1'b1);
        rst_b = 1'b0;
        repeat (4) @(negedge clk);
        chk("b_rst_nop4", cmd_b, C_NOP);
        @(negedge clk);
        chk("b_rst_prea", cmd_b, C_PREA);
        repeat (B_DONE) @(negedge clk);
        chk("b_rst_flag", flag_b, 1'b1);
      end
    join

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
